fifo18_stream_reader: RTL and testbench

Read-side drain engine for the 36-bit FIFO18 wrapper. It issues read enables into the FIFO18 read port and accounts for the fixed output-register read latency. It checks the 4 per-byte parity bits that the write side generates, and presents words on a valid/ready stream with per-byte error flags. It sits between the FIFO18 primitive wrapper and any downstream consumer, and it also exposes word and error counters for debug.

---
 rtl/fifo18_stream_reader.sv | 136 +++++++++++++
 tb/tb_fifo18_stream_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo18_stream_reader.sv
// fifo18_stream_reader
//   Read-side drain engine for the 36-bit FIFO18 wrapper. It issues RDEN
//   against a credit that counts buffered and in-flight words, realigns
//   returning data with a RD_LAT-deep valid pipe, and checks the per-byte
//   parity written alongside each word. Words leave on a valid/ready stream
//   through a small circular output buffer.
//
// Ports
//   clk, rst           : FIFO RDCLK domain, synchronous active-high reset
//   en                 : drain enable (in-flight reads always complete)
//   fifo_empty         : FIFO EMPTY flag
//   fifo_rden          : FIFO RDEN
//   fifo_dout/fifo_dop : FIFO DO / DOP, valid RD_LAT cycles after RDEN
//   m_data/m_perr      : stream word and per-byte parity mismatch flags
//   m_valid/m_ready    : stream handshake
//   perr_sticky        : set by any errored word, cleared by perr_clr
//   perr_clr           : clears perr_sticky and err_cnt
//   word_cnt           : words delivered (wraps)
//   err_cnt            : errored words delivered (saturates)
module fifo18_stream_reader #(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned OBUF_DEPTH = 4,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    output logic                 fifo_rden,
    input  logic [31:0]          fifo_dout,
    input  logic [3:0]           fifo_dop,
    output logic [31:0]          m_data,
    output logic [3:0]           m_perr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 perr_sticky,
    input  logic                 perr_clr,
    output logic [31:0]          word_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = OCC_W + 2;

    logic [RD_LAT-1:0] vpipe;
    logic [OCC_W-1:0]  occ;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       mem_data [OBUF_DEPTH];
    logic [3:0]        mem_perr [OBUF_DEPTH];

    logic [SUM_W-1:0]  inflight;
    logic [SUM_W-1:0]  credit_sum;
    logic [3:0]        perr_in;
    logic              push;
    logic              pop;

    // Number of reads issued whose data has not yet reached the buffer.
    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < RD_LAT; k++) begin
            inflight = inflight + SUM_W'(vpipe[k]);
        end
    end

    assign credit_sum = SUM_W'(occ) + inflight;

    // Reads are held off during reset: the valid pipe is cleared on that
    // edge, so a word fetched then would be lost from the FIFO.
    assign fifo_rden = ~rst & en & ~fifo_empty & (credit_sum < SUM_W'(OBUF_DEPTH));

    // Write side packs DIP as {P(byte0), P(byte1), P(byte2), P(byte3)},
    // so byte i is checked against dop[3-i].
    always_comb begin
        perr_in = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            perr_in[i] = (^fifo_dout[8*i +: 8]) ^ fifo_dop[3-i];
        end
    end

    assign push    = vpipe[RD_LAT-1];
    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = mem_data[rd_ptr];
    assign m_perr  = mem_perr[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe       <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_cnt    <= '0;
            err_cnt     <= '0;
            perr_sticky <= 1'b0;
            for (int unsigned e = 0; e < OBUF_DEPTH; e++) begin
                mem_data[e] <= '0;
                mem_perr[e] <= '0;
            end
        end else begin
            vpipe[0] <= fifo_rden;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                vpipe[k] <= vpipe[k-1];
            end

            // Credit check guarantees a free slot whenever push is high.
            if (push) begin
                mem_data[wr_ptr] <= fifo_dout;
                mem_perr[wr_ptr] <= perr_in;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                word_cnt <= word_cnt + 32'd1;
            end

            occ <= occ + OCC_W'(push) - OCC_W'(pop);

            // An errored pop takes priority over a coincident clear.
            if (pop && (|m_perr)) begin
                perr_sticky <= 1'b1;
                if (perr_clr) begin
                    err_cnt <= ERR_CNT_W'(1);
                end else if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end else if (perr_clr) begin
                perr_sticky <= 1'b0;
                err_cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo18_stream_reader.sv
module tb_fifo18_stream_reader;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ERR_W = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  dop;
    } fword_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  perr;
    } exp_t;

    typedef struct packed {
        logic [31:0] dout;
        logic [3:0]  dop;
        logic [3:0]  perr;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic             fifo_empty = 1'b1;
    logic             fifo_rden;
    logic [31:0]      fifo_dout;
    logic [3:0]       fifo_dop;
    logic [31:0]      m_data;
    logic [3:0]       m_perr;
    logic             m_valid;
    logic             m_ready;
    logic             perr_sticky;
    logic             perr_clr;
    logic [31:0]      word_cnt;
    logic [ERR_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int rden_pulses = 0;
    int bad_rd   = 0;

    fword_t fifo_q [$];
    exp_t   exp_q  [$];
    logic [31:0] md [LAT];
    logic [3:0]  mp [LAT];
    vec_t   vecs [11];

    fifo18_stream_reader #(
        .RD_LAT    (LAT),
        .OBUF_DEPTH(DEPTH),
        .ERR_CNT_W (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_dout  (fifo_dout),
        .fifo_dop   (fifo_dop),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .perr_sticky(perr_sticky),
        .perr_clr   (perr_clr),
        .word_cnt   (word_cnt),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO18 read-port model: data appears LAT cycles after RDEN; junk otherwise.
    assign fifo_dout = md[LAT-1];
    assign fifo_dop  = mp[LAT-1];

    always @(posedge clk) begin
        fword_t w;
        w.data = $urandom;
        w.dop  = 4'($urandom);
        if (fifo_rden) begin
            rden_pulses++;
            if (fifo_empty || fifo_q.size() == 0) bad_rd++;
            else w = fifo_q.pop_front();
        end
        md[0] <= w.data;
        mp[0] <= w.dop;
        for (int k = 1; k < LAT; k++) begin
            md[k] <= md[k-1];
            mp[k] <= mp[k-1];
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: compare every accepted stream word with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", m_data);
            end else begin
                e = exp_q.pop_front();
                check("stream_data", m_data, e.data);
                check("stream_perr", {28'd0, m_perr}, {28'd0, e.perr});
            end
        end
    end

    function automatic logic [3:0] dop_good(input logic [31:0] d);
        return {^d[7:0], ^d[15:8], ^d[23:16], ^d[31:24]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] dop, input logic [3:0] perr);
        fword_t f;
        exp_t   e;
        f.data = d;
        f.dop  = dop;
        e.data = d;
        e.perr = perr;
        fifo_q.push_back(f);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input bit rand_ready);
        int idle = 0;
        int n    = 0;
        while (idle < 8 && n < 3000) begin
            step();
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !m_valid) idle++;
            else idle = 0;
            n++;
        end
        check("drain_done", 32'(idle >= 8), 32'd1);
        m_ready = 1'b1;
    endtask

    task automatic wait_not_empty();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fifo_empty && n < 50);
        check("empty_fall_seen", 32'(!fifo_empty), 32'd1);
    endtask

    initial begin
        int lat;
        int nerr;
        int vcnt;
        int n;

        vecs[0]  = '{32'h04030201, 4'b1101, 4'b0000};
        vecs[1]  = '{32'h04030201, 4'b0101, 4'b0001};
        vecs[2]  = '{32'h04030201, 4'b1001, 4'b0010};
        vecs[3]  = '{32'h00000000, 4'b0000, 4'b0000};
        vecs[4]  = '{32'h00000000, 4'b1111, 4'b1111};
        vecs[5]  = '{32'hFFFFFFFF, 4'b0000, 4'b0000};
        vecs[6]  = '{32'hFFFFFFFF, 4'b0010, 4'b0100};
        vecs[7]  = '{32'h80FF0107, 4'b1101, 4'b0000};
        vecs[8]  = '{32'h80FF0107, 4'b1100, 4'b1000};
        vecs[9]  = '{32'h12345678, 4'b0010, 4'b0000};
        vecs[10] = '{32'h12345678, 4'b1000, 4'b0101};

        rst      = 1'b1;
        en       = 1'b1;
        m_ready  = 1'b1;
        perr_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        check("rst_rden",   32'(fifo_rden),   32'd0);
        check("rst_valid",  32'(m_valid),     32'd0);
        check("rst_data",   m_data,           32'd0);
        check("rst_perr",   32'(m_perr),      32'd0);
        check("rst_sticky", 32'(perr_sticky), 32'd0);
        check("rst_words",  word_cnt,         32'd0);
        check("rst_errs",   32'(err_cnt),     32'd0);

        // First-word latency and a clean word.
        push_word(32'h04030201, 4'b1101, 4'b0000);
        wait_not_empty();
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("first_latency", 32'(lat), 32'(LAT + 1));
        drain(1'b0);
        check("t1_words",  word_cnt,         32'd1);
        check("t1_errs",   32'(err_cnt),     32'd0);
        check("t1_sticky", 32'(perr_sticky), 32'd0);

        // Byte0 parity error, then clear.
        push_word(32'h04030201, 4'b0101, 4'b0001);
        drain(1'b0);
        check("t2_sticky", 32'(perr_sticky), 32'd1);
        check("t2_errs",   32'(err_cnt),     32'd1);
        check("t2_words",  word_cnt,         32'd2);
        step();
        perr_clr = 1'b1;
        step();
        perr_clr = 1'b0;
        check("clr_sticky", 32'(perr_sticky), 32'd0);
        check("clr_errs",   32'(err_cnt),     32'd0);
        check("clr_words",  word_cnt,         32'd2);

        // Parity table, drained with a random ready pattern.
        do_reset();
        nerr = 0;
        for (int i = 0; i < 11; i++) begin
            push_word(vecs[i].dout, vecs[i].dop, vecs[i].perr);
            if (vecs[i].perr != 4'b0000) nerr++;
        end
        drain(1'b1);
        check("tbl_words",  word_cnt,         32'd11);
        check("tbl_errs",   32'(err_cnt),     32'(nerr));
        check("tbl_sticky", 32'(perr_sticky), 32'd1);

        // 100-word burst at full throughput.
        do_reset();
        for (int i = 0; i < 100; i++) push_word(32'(i), dop_good(32'(i)), 4'b0000);
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        vcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_valid) vcnt++;
            @(negedge clk);
        end
        check("burst_continuous", 32'(vcnt), 32'd100);
        check("burst_end_idle",   32'(m_valid), 32'd0);
        drain(1'b0);
        check("burst_words", word_cnt, 32'd100);

        // Backpressure: reads stop at buffer depth, then drain in order.
        step();
        m_ready = 1'b0;
        rden_pulses = 0;
        for (int i = 0; i < 10; i++) push_word(32'hA0000000 + 32'(i), dop_good(32'hA0000000 + 32'(i)), 4'b0000);
        repeat (20) step();
        check("bp_rden_pulses", 32'(rden_pulses), 32'(DEPTH));
        check("bp_rden_low",    32'(fifo_rden),   32'd0);
        check("bp_hold_data",   m_data,           32'hA0000000);
        m_ready = 1'b1;
        drain(1'b0);
        check("bp_words", word_cnt, 32'd110);

        // Reset with two reads in flight and two words buffered.
        m_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) push_word(32'hB0000000 + 32'(i), dop_good(32'hB0000000 + 32'(i)), 4'b0000);
        wait_not_empty();
        repeat (4) step();
        check("pre_rst_valid", 32'(m_valid),   32'd1);
        check("pre_rst_rden",  32'(fifo_rden), 32'd0);
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        step();
        rst = 1'b0;
        check("post_rst_valid", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_valid) vcnt++;
        end
        check("post_rst_no_data", 32'(vcnt), 32'd0);
        check("post_rst_words",   word_cnt,  32'd0);

        // Error counter saturation and clear coinciding with an errored pop.
        do_reset();
        for (int i = 0; i < 254; i++) push_word(32'(i), dop_good(32'(i)) ^ 4'b0001, 4'b1000);
        drain(1'b0);
        check("sat_pre", 32'(err_cnt), 32'd254);
        push_word(32'h11, dop_good(32'h11) ^ 4'b0001, 4'b1000);
        drain(1'b0);
        check("sat_full", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 2; i++) push_word(32'h20 + 32'(i), dop_good(32'h20 + 32'(i)) ^ 4'b0001, 4'b1000);
        drain(1'b0);
        check("sat_hold", 32'(err_cnt), 32'd255);

        m_ready = 1'b0;
        push_word(32'hCAFE0001, dop_good(32'hCAFE0001) ^ 4'b0001, 4'b1000);
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("coinc_valid", 32'(m_valid), 32'd1);
        step();
        perr_clr = 1'b1;
        m_ready  = 1'b1;
        step();
        perr_clr = 1'b0;
        m_ready  = 1'b0;
        check("coinc_errs",   32'(err_cnt),     32'd1);
        check("coinc_sticky", 32'(perr_sticky), 32'd1);
        check("coinc_words",  word_cnt,         32'd258);
        m_ready = 1'b1;
        drain(1'b0);

        check("rden_while_empty", 32'(bad_rd), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
